// File: rtl/pe_pkg.sv
// Shared widths, drain FSM state type and the wrap/saturate adder for systolic_pe_v2.
// PE_SAT_EN selects saturating arithmetic in sat_add; undefined means two's-complement wrap.
package pe_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int WEIGHT_W_DEF = 8;
  localparam int ACC_W_DEF    = 24;
  // Internal add width; any ACC_W up to 62 bits cannot overflow here.
  localparam int MAX_W        = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic signed [MAX_W-1:0] sum;
    logic                    hit;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      acc_w);
    sat_res_t                r;
    logic signed [MAX_W-1:0] full;
    full  = a + b;
    r.hit = 1'b0;
`ifdef PE_SAT_EN
    begin
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (MAX_W'(64'sd1) <<< (acc_w - 1)) - MAX_W'(64'sd1);
      lo = -hi - MAX_W'(64'sd1);
      r.sum = full;
      if (full > hi) begin
        r.sum = hi;
        r.hit = 1'b1;
      end else if (full < lo) begin
        r.sum = lo;
        r.hit = 1'b1;
      end
    end
`else
    r.sum = (full <<< (MAX_W - acc_w)) >>> (MAX_W - acc_w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe_v2_if.sv
// PE neighbour bus: activation/partial-sum/weight chain plus debug taps of internal state.
// Handshake: no valid/ready; 'active' qualifies compute each cycle and is forwarded as activeout.
interface systolic_pe_v2_if
  import pe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
);
  logic                       active;
  logic signed [DATA_W-1:0]   datain;
  logic signed [ACC_W-1:0]    sumin;
  logic signed [WEIGHT_W-1:0] win;
  logic                       wshift;
  logic                       wswap;
  logic                       os_mode;
  logic                       acc_clear;
  logic                       drain;
  logic signed [DATA_W-1:0]   dataout;
  logic signed [ACC_W-1:0]    maccout;
  logic signed [WEIGHT_W-1:0] wout;
  logic                       wswapout;
  logic                       activeout;
  logic                       ovf;
  drain_state_t               dbg_state;
  logic signed [WEIGHT_W-1:0] dbg_weight;
  logic signed [ACC_W-1:0]    dbg_acc;

  modport master (
    output active, datain, sumin, win, wshift, wswap, os_mode, acc_clear, drain,
    input  dataout, maccout, wout, wswapout, activeout, ovf,
    input  dbg_state, dbg_weight, dbg_acc
  );

  modport slave (
    input  active, datain, sumin, win, wshift, wswap, os_mode, acc_clear, drain,
    output dataout, maccout, wout, wswapout, activeout, ovf,
    output dbg_state, dbg_weight, dbg_acc
  );
endinterface

// File: rtl/pe_mac.sv
// Combinational multiply-add: full-precision signed product plus addend, wrapped or clamped.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [WEIGHT_W-1:0] w,
  input  logic signed [ACC_W-1:0]    addend,
  output logic signed [ACC_W-1:0]    sum,
  output logic                       ovf_hit
);
  logic signed [DATA_W+WEIGHT_W-1:0] prod;
  sat_res_t                          res;
  logic                              unused_hi;

  assign prod      = a * w;
  assign res       = sat_add(MAX_W'(prod), MAX_W'(addend), ACC_W);
  assign sum       = res.sum[ACC_W-1:0];
  assign ovf_hit   = res.hit;
  assign unused_hi = ^res.sum[MAX_W-1:ACC_W];
endmodule

// File: rtl/systolic_pe_v2.sv
// Double-buffered-weight systolic PE with weight-stationary and output-stationary dataflows.
// Define PE_SAT_EN for saturating arithmetic and a sticky ovf flag.
module systolic_pe_v2
  import pe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  systolic_pe_v2_if.slave pe
);
  drain_state_t               state_q;
  logic signed [WEIGHT_W-1:0] weight_q;
  logic signed [WEIGHT_W-1:0] shadow_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   dataout_q;
  logic signed [ACC_W-1:0]    maccout_q;
  logic                       wswapout_q;
  logic                       activeout_q;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    mac_sum;
  logic                       mac_hit;
  logic                       mac_used;

  // One MAC serves both dataflows: WS adds the incoming partial sum, OS adds the local acc.
  assign addend   = pe.os_mode ? (pe.acc_clear ? '0 : acc_q) : pe.sumin;
  assign mac_used = pe.active && (!pe.os_mode || (state_q == IDLE && !pe.drain));

  pe_mac #(
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W)
  ) u_mac (
    .a      (pe.datain),
    .w      (weight_q),
    .addend (addend),
    .sum    (mac_sum),
    .ovf_hit(mac_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      weight_q    <= '0;
      shadow_q    <= '0;
      acc_q       <= '0;
      dataout_q   <= '0;
      maccout_q   <= '0;
      wswapout_q  <= 1'b0;
      activeout_q <= 1'b0;
    end else begin
      activeout_q <= pe.active;
      wswapout_q  <= pe.wswap;
      // Swap takes the pre-edge shadow, so a same-edge shift lands one load later.
      if (pe.wshift) shadow_q <= pe.win;
      if (pe.wswap)  weight_q <= shadow_q;
      if (pe.active) dataout_q <= pe.datain;
      if (!pe.os_mode) begin
        state_q <= IDLE;
        if (pe.active) maccout_q <= mac_sum;
      end else begin
        case (state_q)
          IDLE: begin
            if (pe.drain)       state_q <= LOAD;
            else if (pe.active) acc_q   <= mac_sum;
          end
          LOAD: begin
            maccout_q <= acc_q;
            acc_q     <= '0;
            state_q   <= pe.drain ? SHIFT : IDLE;
          end
          SHIFT: begin
            if (pe.drain) maccout_q <= pe.sumin;
            else          state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef PE_SAT_EN
  logic ovf_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      if (pe.active && pe.acc_clear) ovf_q <= 1'b0;
      if (mac_used && mac_hit)       ovf_q <= 1'b1;
    end
  end
  assign pe.ovf = ovf_q;
`else
  logic unused_hit;
  assign unused_hit = mac_hit;
  assign pe.ovf     = 1'b0;
`endif

  assign pe.dataout    = dataout_q;
  assign pe.maccout    = maccout_q;
  assign pe.wout       = shadow_q;
  assign pe.wswapout   = wswapout_q;
  assign pe.activeout  = activeout_q;
  assign pe.dbg_state  = state_q;
  assign pe.dbg_weight = weight_q;
  assign pe.dbg_acc    = acc_q;
endmodule

// File: tb/tb_systolic_pe_v2.sv
// Self-checking bench for systolic_pe_v2 (ACC_W=16); expected sums come from a wrap/saturate model.
module tb_systolic_pe_v2;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int ACC_MAX = (1 <<< (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 <<< (AW - 1));

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_v;
  logic [AW-1:0] last_macc;
`ifdef PE_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  systolic_pe_v2_if #(.DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW)) pe_bus ();

  systolic_pe_v2 #(.DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW)) dut (
    .clock(clock),
    .reset(reset),
    .pe   (pe_bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] model_add(input int s, input int p);
    int r;
    r = s + p;
    if (SAT) begin
      if (r > ACC_MAX) r = ACC_MAX;
      if (r < ACC_MIN) r = ACC_MIN;
    end
    return AW'(r);
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pe_bus.active    = 1'b0;
    pe_bus.datain    = '0;
    pe_bus.sumin     = '0;
    pe_bus.win       = '0;
    pe_bus.wshift    = 1'b0;
    pe_bus.wswap     = 1'b0;
    pe_bus.os_mode   = 1'b0;
    pe_bus.acc_clear = 1'b0;
    pe_bus.drain     = 1'b0;
  endtask

  task automatic load_weight(input int w);
    pe_bus.active = 1'b0;
    pe_bus.win    = WW'(w);
    pe_bus.wshift = 1'b1;
    step();
    pe_bus.wshift = 1'b0;
    pe_bus.wswap  = 1'b1;
    step();
    pe_bus.wswap  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({pe_bus.dataout, pe_bus.maccout, pe_bus.wout, pe_bus.wswapout, pe_bus.activeout,
         pe_bus.ovf, pe_bus.dbg_weight, pe_bus.dbg_acc} !== '0 || pe_bus.dbg_state !== IDLE) begin
      $display("FAIL reset_init: dout=%h macc=%h wout=%h ovf=%b w=%h acc=%h st=%0d, required all 0",
               pe_bus.dataout, pe_bus.maccout, pe_bus.wout, pe_bus.ovf, pe_bus.dbg_weight,
               pe_bus.dbg_acc, pe_bus.dbg_state);
      failures++;
    end
    @(negedge clock);
    reset = 1'b0;
    load_weight(5);
    pe_bus.os_mode   = 1'b1;
    pe_bus.active    = 1'b1;
    pe_bus.acc_clear = 1'b1;
    pe_bus.datain    = DW'(3);
    pe_bus.win       = WW'(6);
    pe_bus.wshift    = 1'b1;
    step();
    pe_bus.acc_clear = 1'b0;
    pe_bus.wshift    = 1'b0;
    step();
    checks++;
    if (pe_bus.dbg_acc !== AW'(30)) begin
      $display("FAIL reset_preacc: acc=%0d required 30", $signed(pe_bus.dbg_acc));
      failures++;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({pe_bus.dataout, pe_bus.maccout, pe_bus.wout, pe_bus.wswapout, pe_bus.activeout,
         pe_bus.ovf, pe_bus.dbg_weight, pe_bus.dbg_acc} !== '0 || pe_bus.dbg_state !== IDLE) begin
      $display("FAIL reset_async: dout=%h wout=%h act=%b w=%h acc=%h st=%0d, required all 0",
               pe_bus.dataout, pe_bus.wout, pe_bus.activeout, pe_bus.dbg_weight,
               pe_bus.dbg_acc, pe_bus.dbg_state);
      failures++;
    end
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    last_macc = '0;
  endtask

  task automatic test_ws();
    int d;
    int s;
    load_weight(3);
    checks++;
    if (pe_bus.dbg_weight !== WW'(3)) begin
      $display("FAIL ws_weight: weight=%0d required 3", $signed(pe_bus.dbg_weight));
      failures++;
    end
    pe_bus.os_mode = 1'b0;
    pe_bus.active  = 1'b1;
    pe_bus.datain  = DW'(-5);
    pe_bus.sumin   = AW'(100);
    exp_q.push_back(AW'(85));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.dataout !== DW'(-5) || pe_bus.activeout !== 1'b1) begin
      $display("FAIL ws_basic: macc=%0d dout=%0d act=%b required macc=%0d dout=-5 act=1",
               $signed(pe_bus.maccout), $signed(pe_bus.dataout), pe_bus.activeout, $signed(exp_v));
      failures++;
    end
    last_macc = exp_v;
    pe_bus.active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pe_bus.datain = DW'($urandom_range(0, 255));
      pe_bus.sumin  = AW'($urandom_range(0, 65535));
      step();
      checks++;
      if (pe_bus.maccout !== last_macc || pe_bus.dataout !== DW'(-5) || pe_bus.activeout !== 1'b0) begin
        $display("FAIL ws_stall[%0d]: macc=%0d dout=%0d act=%b required macc=%0d dout=-5 act=0",
                 i, $signed(pe_bus.maccout), $signed(pe_bus.dataout), pe_bus.activeout,
                 $signed(last_macc));
        failures++;
      end
    end
    pe_bus.active = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 255)) - 128;
      s = int'($urandom_range(0, 2000)) - 1000;
      pe_bus.datain = DW'(d);
      pe_bus.sumin  = AW'(s);
      exp_q.push_back(model_add(s, d * 3));
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (pe_bus.maccout !== exp_v || pe_bus.dataout !== DW'(d)) begin
        $display("FAIL ws_rand[%0d]: macc=%0d dout=%0d required macc=%0d dout=%0d",
                 i, $signed(pe_bus.maccout), $signed(pe_bus.dataout), $signed(exp_v), d);
        failures++;
      end
      last_macc = exp_v;
    end
    pe_bus.active = 1'b0;
  endtask

  task automatic test_double_buffer();
    load_weight(2);
    pe_bus.os_mode = 1'b0;
    pe_bus.active  = 1'b1;
    pe_bus.sumin   = '0;
    pe_bus.datain  = DW'(5);
    pe_bus.win     = WW'(7);
    pe_bus.wshift  = 1'b1;
    exp_q.push_back(AW'(10));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.wout !== WW'(7) || pe_bus.dbg_weight !== WW'(2)) begin
      $display("FAIL db_shift: macc=%0d wout=%0d w=%0d required macc=%0d wout=7 w=2",
               $signed(pe_bus.maccout), pe_bus.wout, pe_bus.dbg_weight, $signed(exp_v));
      failures++;
    end
    pe_bus.wshift = 1'b0;
    pe_bus.datain = DW'(6);
    exp_q.push_back(AW'(12));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v) begin
      $display("FAIL db_hold: macc=%0d required %0d", $signed(pe_bus.maccout), $signed(exp_v));
      failures++;
    end
    pe_bus.wshift = 1'b1;
    pe_bus.wswap  = 1'b1;
    pe_bus.win    = WW'(9);
    pe_bus.datain = DW'(1);
    exp_q.push_back(AW'(2));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.dbg_weight !== WW'(7) || pe_bus.wout !== WW'(9) ||
        pe_bus.wswapout !== 1'b1) begin
      $display("FAIL db_same_edge: macc=%0d w=%0d wout=%0d swo=%b required macc=%0d w=7 wout=9 swo=1",
               $signed(pe_bus.maccout), pe_bus.dbg_weight, pe_bus.wout, pe_bus.wswapout, $signed(exp_v));
      failures++;
    end
    pe_bus.wshift = 1'b0;
    pe_bus.wswap  = 1'b0;
    exp_q.push_back(AW'(7));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.wswapout !== 1'b0) begin
      $display("FAIL db_new_weight: macc=%0d swo=%b required macc=%0d swo=0",
               $signed(pe_bus.maccout), pe_bus.wswapout, $signed(exp_v));
      failures++;
    end
    last_macc = exp_v;
    pe_bus.active = 1'b0;
  endtask

  task automatic test_os();
    int acc;
    load_weight(4);
    pe_bus.os_mode = 1'b1;
    pe_bus.active  = 1'b1;
    pe_bus.datain  = DW'(10);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      pe_bus.acc_clear = (i == 0);
      acc = ((i == 0) ? 0 : acc) + 40;
      step();
    end
    pe_bus.acc_clear = 1'b0;
    checks++;
    if (pe_bus.dbg_acc !== AW'(acc) || pe_bus.maccout !== last_macc || pe_bus.dataout !== DW'(10)) begin
      $display("FAIL os_accum: acc=%0d macc=%0d dout=%0d required acc=%0d macc=%0d dout=10",
               $signed(pe_bus.dbg_acc), $signed(pe_bus.maccout), $signed(pe_bus.dataout), acc,
               $signed(last_macc));
      failures++;
    end
    pe_bus.drain  = 1'b1;
    pe_bus.datain = DW'(20);
    step();
    checks++;
    if (pe_bus.dbg_state !== LOAD || pe_bus.dbg_acc !== AW'(acc)) begin
      $display("FAIL os_drain_start: st=%0d acc=%0d required st=LOAD acc=%0d",
               pe_bus.dbg_state, $signed(pe_bus.dbg_acc), acc);
      failures++;
    end
    exp_q.push_back(AW'(acc));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.dbg_acc !== '0 || pe_bus.dbg_state !== SHIFT ||
        pe_bus.dataout !== DW'(20)) begin
      $display("FAIL os_load: macc=%0d acc=%0d st=%0d dout=%0d required macc=%0d acc=0 st=SHIFT dout=20",
               $signed(pe_bus.maccout), $signed(pe_bus.dbg_acc), pe_bus.dbg_state,
               $signed(pe_bus.dataout), $signed(exp_v));
      failures++;
    end
    for (int i = 1; i <= 2; i++) begin
      pe_bus.sumin = AW'(11 * i);
      exp_q.push_back(AW'(11 * i));
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (pe_bus.maccout !== exp_v) begin
        $display("FAIL os_shift[%0d]: macc=%0d required %0d", i, $signed(pe_bus.maccout), $signed(exp_v));
        failures++;
      end
      last_macc = exp_v;
    end
    pe_bus.drain = 1'b0;
    step();
    checks++;
    if (pe_bus.dbg_state !== IDLE || pe_bus.dbg_acc !== '0 || pe_bus.maccout !== last_macc) begin
      $display("FAIL os_drain_end: st=%0d acc=%0d macc=%0d required st=IDLE acc=0 macc=%0d",
               pe_bus.dbg_state, $signed(pe_bus.dbg_acc), $signed(pe_bus.maccout), $signed(last_macc));
      failures++;
    end
    pe_bus.active = 1'b0;
  endtask

  task automatic test_saturation();
    load_weight(1);
    pe_bus.os_mode = 1'b0;
    pe_bus.active  = 1'b1;
    pe_bus.datain  = DW'(1);
    pe_bus.sumin   = AW'(ACC_MAX);
    exp_q.push_back(model_add(ACC_MAX, 1));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.ovf !== SAT) begin
      $display("FAIL sat_pos: macc=%0d ovf=%b required macc=%0d ovf=%b",
               $signed(pe_bus.maccout), pe_bus.ovf, $signed(exp_v), SAT);
      failures++;
    end
    pe_bus.datain = DW'(-1);
    pe_bus.sumin  = AW'(ACC_MIN);
    exp_q.push_back(model_add(ACC_MIN, -1));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.ovf !== SAT) begin
      $display("FAIL sat_neg: macc=%0d ovf=%b required macc=%0d ovf=%b",
               $signed(pe_bus.maccout), pe_bus.ovf, $signed(exp_v), SAT);
      failures++;
    end
    pe_bus.datain    = '0;
    pe_bus.sumin     = '0;
    pe_bus.acc_clear = 1'b1;
    exp_q.push_back(AW'(0));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.ovf !== 1'b0) begin
      $display("FAIL sat_clear: macc=%0d ovf=%b required macc=0 ovf=0",
               $signed(pe_bus.maccout), pe_bus.ovf);
      failures++;
    end
    pe_bus.acc_clear = 1'b0;
    pe_bus.active    = 1'b0;
    last_macc        = exp_v;
  endtask

  task automatic test_mode_switch();
    pe_bus.os_mode   = 1'b1;
    pe_bus.active    = 1'b1;
    pe_bus.acc_clear = 1'b1;
    pe_bus.datain    = DW'(3);
    step();
    pe_bus.acc_clear = 1'b0;
    step();
    pe_bus.os_mode = 1'b0;
    pe_bus.datain  = DW'(2);
    pe_bus.sumin   = AW'(50);
    exp_q.push_back(AW'(52));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.maccout !== exp_v || pe_bus.dbg_acc !== AW'(6)) begin
      $display("FAIL mode_ws_keeps_acc: macc=%0d acc=%0d required macc=%0d acc=6",
               $signed(pe_bus.maccout), $signed(pe_bus.dbg_acc), $signed(exp_v));
      failures++;
    end
    pe_bus.os_mode = 1'b1;
    pe_bus.active  = 1'b0;
    pe_bus.drain   = 1'b1;
    step();
    exp_q.push_back(AW'(6));
    step();
    pe_bus.sumin = AW'(33);
    exp_q.push_back(AW'(33));
    step();
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (i == 1 && (pe_bus.maccout !== exp_v || pe_bus.dbg_state !== SHIFT)) begin
        $display("FAIL mode_shift: macc=%0d st=%0d required macc=%0d st=SHIFT",
                 $signed(pe_bus.maccout), pe_bus.dbg_state, $signed(exp_v));
        failures++;
      end else if (i == 0 && exp_v !== AW'(6)) begin
        $display("FAIL mode_queue: entry=%0d required 6", $signed(exp_v));
        failures++;
      end
    end
    pe_bus.os_mode = 1'b0;
    pe_bus.active  = 1'b1;
    pe_bus.datain  = DW'(4);
    pe_bus.sumin   = AW'(100);
    exp_q.push_back(AW'(104));
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (pe_bus.dbg_state !== IDLE || pe_bus.maccout !== exp_v) begin
      $display("FAIL mode_switch: st=%0d macc=%0d required st=IDLE macc=%0d",
               pe_bus.dbg_state, $signed(pe_bus.maccout), $signed(exp_v));
      failures++;
    end
    idle_inputs();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    last_macc = '0;
    reset     = 1'b1;
    idle_inputs();
    test_reset();
    test_ws();
    test_double_buffer();
    test_os();
    test_saturation();
    test_mode_switch();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL queue_empty: %0d entries left, required 0", exp_q.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
